// File: rtl/pwm_capture_if.sv
// Measurement bus between pwm_capture (master) and the consuming processor (slave).
interface pwm_capture_if #(
    parameter int G_CNT_WIDTH = 16
);
    logic                   i_ack;
    logic [G_CNT_WIDTH-1:0] o_high;
    logic [G_CNT_WIDTH-1:0] o_period;
    logic                   o_valid;
    logic                   o_static;
    logic                   o_level;
    logic                   o_overrun;

    modport master (
        input  i_ack,
        output o_high, o_period, o_valid, o_static, o_level, o_overrun
    );

    modport slave (
        output i_ack,
        input  o_high, o_period, o_valid, o_static, o_level, o_overrun
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in i_clk cycles.
// Optional majority glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int G_CNT_WIDTH = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_pwm,
    pwm_capture_if.master bus
);
    localparam logic [G_CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [G_CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [G_CNT_WIDTH-1:0] CNT_ONE  = {{(G_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, MEASURE} state_t;

    function automatic logic [G_CNT_WIDTH-1:0] sat_inc(input logic [G_CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic sync1_q, sync2_q, prev_q;
    logic lvl, lvl_prev, rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= i_pwm;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Majority over three registered samples: a single-cycle pulse never wins the vote.
    logic prev2_q, filt_prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev2_q     <= 1'b0;
            filt_prev_q <= 1'b0;
        end else begin
            prev2_q     <= prev_q;
            filt_prev_q <= lvl;
        end
    end

    assign lvl      = majority(sync2_q, prev_q, prev2_q);
    assign lvl_prev = filt_prev_q;
`else
    assign lvl      = sync2_q;
    assign lvl_prev = prev_q;
`endif

    assign rise = lvl & ~lvl_prev;

    state_t                 state_q, state_d;
    logic [G_CNT_WIDTH-1:0] per_cnt_q, per_cnt_d, high_cnt_q, high_cnt_d;
    logic [G_CNT_WIDTH-1:0] high_q, high_d, period_q, period_d;
    logic                   valid_q, valid_d, static_q, static_d;
    logic                   level_q, level_d, overrun_q, overrun_d;
    logic                   latch;

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        high_cnt_d = high_cnt_q;
        high_d     = high_q;
        period_d   = period_q;
        static_d   = static_q;
        level_d    = level_q;
        latch      = 1'b0;

        case (state_q)
            IDLE: begin
                per_cnt_d  = CNT_ZERO;
                high_cnt_d = CNT_ZERO;
                if (rise) begin
                    state_d    = MEASURE;
                    per_cnt_d  = CNT_ONE;
                    high_cnt_d = CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    latch      = 1'b1;
                    period_d   = per_cnt_q;
                    high_d     = high_cnt_q;
                    static_d   = 1'b0;
                    per_cnt_d  = CNT_ONE;
                    high_cnt_d = CNT_ONE;
                end else if (per_cnt_q == CNT_MAX) begin
                    // No rising edge in the full counter range: report a static line.
                    latch      = 1'b1;
                    period_d   = CNT_MAX;
                    high_d     = lvl ? CNT_MAX : CNT_ZERO;
                    level_d    = lvl;
                    static_d   = 1'b1;
                    state_d    = IDLE;
                    per_cnt_d  = CNT_ZERO;
                    high_cnt_d = CNT_ZERO;
                end else begin
                    per_cnt_d = sat_inc(per_cnt_q);
                    if (lvl) begin
                        high_cnt_d = sat_inc(high_cnt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Ack consumes the held result; a simultaneous latch re-arms valid without overrun.
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (bus.i_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (latch) begin
            valid_d = 1'b1;
            if (valid_q && !bus.i_ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            per_cnt_q  <= CNT_ZERO;
            high_cnt_q <= CNT_ZERO;
            high_q     <= CNT_ZERO;
            period_q   <= CNT_ZERO;
            valid_q    <= 1'b0;
            static_q   <= 1'b0;
            level_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            high_q     <= high_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            static_q   <= static_d;
            level_q    <= level_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.o_high    = high_q;
    assign bus.o_period  = period_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_static  = static_q;
    assign bus.o_level   = level_q;
    assign bus.o_overrun = overrun_q;
endmodule
